// File: rtl/cu_tile_scheduler.sv
// cu_tile_scheduler
//   Sequences a tiled attention job over a compute unit: for every
//   (q_idx, kv_idx) pair it fetches the Q/K tiles, runs the QK phase, fetches
//   the V tile and runs the SV phase. Result pulses from the compute unit are
//   turned into output-buffer writes. After the last tile the block drains
//   until the compute unit has been quiet for DRAIN_QUIET cycles. A per-state
//   watchdog traps stalled handshakes in a sticky error state.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   i_start, i_abort                job start pulse / abandon job
//   i_num_q, i_num_kv               tile counts, sampled with i_start
//   o_qk_fetch_req/i_qk_fetch_ack   Q/K tile fetch handshake
//   o_v_fetch_req/i_v_fetch_ack     V tile fetch handshake
//   o_cu_valid                      data/index valid to the compute unit
//   i_cu_qk_over, i_cu_over         QK-phase done, SV-phase done pulses
//   i_cu_data_valid                 compute-unit result valid pulse
//   o_q_idx, o_kv_idx               current tile indices
//   o_wr_en, o_wr_addr              output-buffer write strobe / address
//   o_busy, o_done, o_err           job active, completion pulse, sticky error
module cu_tile_scheduler #(
  parameter int CNT_WIDTH   = 8,
  parameter int TIMEOUT     = 1023,
  parameter int DRAIN_QUIET = 16,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [CNT_WIDTH-1:0]  i_num_q,
  input  logic [CNT_WIDTH-1:0]  i_num_kv,
  output logic                  o_qk_fetch_req,
  input  logic                  i_qk_fetch_ack,
  output logic                  o_v_fetch_req,
  input  logic                  i_v_fetch_ack,
  output logic                  o_cu_valid,
  input  logic                  i_cu_qk_over,
  input  logic                  i_cu_over,
  input  logic                  i_cu_data_valid,
  output logic [CNT_WIDTH-1:0]  o_q_idx,
  output logic [CNT_WIDTH-1:0]  o_kv_idx,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int QW   = $clog2(DRAIN_QUIET + 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [QW-1:0]   QUIET_END = QW'(DRAIN_QUIET);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_QK = 3'd1,
    QK       = 3'd2,
    FETCH_V  = 3'd3,
    SV       = 3'd4,
    DRAIN    = 3'd5,
    ERR      = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  num_q_q, num_q_d;
  logic [CNT_WIDTH-1:0]  num_kv_q, num_kv_d;
  logic [CNT_WIDTH-1:0]  q_idx_q, q_idx_d;
  logic [CNT_WIDTH-1:0]  kv_idx_q, kv_idx_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [QW-1:0]         quiet_q, quiet_d;
  logic                  qk_req_q, qk_req_d;
  logic                  v_req_q, v_req_d;
  logic                  cu_valid_q, cu_valid_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  timeout_hit;
  logic                  watched;
  logic [QW-1:0]         quiet_inc;

  always_comb begin
    state_d   = state_q;
    num_q_d   = num_q_q;
    num_kv_d  = num_kv_q;
    q_idx_d   = q_idx_q;
    kv_idx_d  = kv_idx_q;
    quiet_d   = '0;
    done_d    = 1'b0;
    // The address advances in the cycle after a write is presented, so the
    // strobe and the address it targets appear together.
    wr_addr_d = wr_addr_q + ADDR_WIDTH'(wr_en_q);
    wr_en_d   = i_cu_data_valid && (state_q != IDLE) && (state_q != ERR);

    timeout_hit = (wd_q == WD_LAST);
    quiet_inc   = quiet_q + QW'(1);
    watched     = (state_q == FETCH_QK) || (state_q == QK) ||
                  (state_q == FETCH_V)  || (state_q == SV);

    case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          if ((i_num_q != '0) && (i_num_kv != '0)) begin
            num_q_d   = i_num_q;
            num_kv_d  = i_num_kv;
            q_idx_d   = '0;
            kv_idx_d  = '0;
            wr_addr_d = '0;
            state_d   = FETCH_QK;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH_QK: begin
        if (i_qk_fetch_ack)   state_d = QK;
        else if (timeout_hit) state_d = ERR;
      end
      QK: begin
        if (i_cu_qk_over)     state_d = FETCH_V;
        else if (timeout_hit) state_d = ERR;
      end
      FETCH_V: begin
        if (i_v_fetch_ack)    state_d = SV;
        else if (timeout_hit) state_d = ERR;
      end
      SV: begin
        if (i_cu_over) begin
          if (kv_idx_q == num_kv_q - CNT_WIDTH'(1)) begin
            kv_idx_d = '0;
            q_idx_d  = q_idx_q + CNT_WIDTH'(1);
            if (q_idx_q == num_q_q - CNT_WIDTH'(1)) state_d = DRAIN;
            else                                      state_d = FETCH_QK;
          end else begin
            kv_idx_d = kv_idx_q + CNT_WIDTH'(1);
            state_d  = FETCH_QK;
          end
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      DRAIN: begin
        if (!i_cu_data_valid) begin
          quiet_d = quiet_inc;
          if (quiet_inc == QUIET_END) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ERR: state_d = ERR;
      default: state_d = IDLE;
    endcase

    // Abort wins over any same-cycle handshake: indices keep their
    // pre-abort values and no completion is reported.
    if (i_abort && (state_q != ERR)) begin
      state_d  = IDLE;
      q_idx_d  = q_idx_q;
      kv_idx_d = kv_idx_q;
      done_d   = 1'b0;
    end

    if ((state_d != state_q) || !watched) wd_d = '0;
    else                                  wd_d = wd_q + WD_W'(1);

    // Outputs follow the next state so they line up with the registered state.
    qk_req_d   = (state_d == FETCH_QK);
    v_req_d    = (state_d == FETCH_V);
    cu_valid_d = (state_d == QK);
    busy_d     = (state_d != IDLE) && (state_d != ERR);
    err_d      = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      num_q_q    <= '0;
      num_kv_q   <= '0;
      q_idx_q    <= '0;
      kv_idx_q   <= '0;
      wd_q       <= '0;
      quiet_q    <= '0;
      qk_req_q   <= 1'b0;
      v_req_q    <= 1'b0;
      cu_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q_q    <= num_q_d;
      num_kv_q   <= num_kv_d;
      q_idx_q    <= q_idx_d;
      kv_idx_q   <= kv_idx_d;
      wd_q       <= wd_d;
      quiet_q    <= quiet_d;
      qk_req_q   <= qk_req_d;
      v_req_q    <= v_req_d;
      cu_valid_q <= cu_valid_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_qk_fetch_req = qk_req_q;
  assign o_v_fetch_req  = v_req_q;
  assign o_cu_valid     = cu_valid_q;
  assign o_q_idx        = q_idx_q;
  assign o_kv_idx       = kv_idx_q;
  assign o_wr_en        = wr_en_q;
  assign o_wr_addr      = wr_addr_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_cu_tile_scheduler.sv
// Directed testbench for cu_tile_scheduler (default parameters).
module tb_cu_tile_scheduler;

  localparam int CW = 8;
  localparam int AW = 10;
  localparam int TO = 1023;
  localparam int DQ = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0, i_abort = 1'b0;
  logic [CW-1:0] i_num_q = '0, i_num_kv = '0;
  logic          i_qk_fetch_ack = 1'b0, i_v_fetch_ack = 1'b0;
  logic          i_cu_qk_over = 1'b0, i_cu_over = 1'b0, i_cu_data_valid = 1'b0;
  logic          o_qk_fetch_req, o_v_fetch_req, o_cu_valid;
  logic [CW-1:0] o_q_idx, o_kv_idx;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic          o_busy, o_done, o_err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  cu_tile_scheduler #(.CNT_WIDTH(CW), .TIMEOUT(TO), .DRAIN_QUIET(DQ), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_num_q(i_num_q), .i_num_kv(i_num_kv),
    .o_qk_fetch_req(o_qk_fetch_req), .i_qk_fetch_ack(i_qk_fetch_ack),
    .o_v_fetch_req(o_v_fetch_req), .i_v_fetch_ack(i_v_fetch_ack),
    .o_cu_valid(o_cu_valid), .i_cu_qk_over(i_cu_qk_over), .i_cu_over(i_cu_over),
    .i_cu_data_valid(i_cu_data_valid), .o_q_idx(o_q_idx), .o_kv_idx(o_kv_idx),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_done === 1'b1) done_cnt++;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int nq, input int nkv);
    i_num_q = CW'(nq); i_num_kv = CW'(nkv); i_start = 1'b1;
    cyc();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    checks++;
    if ({o_qk_fetch_req, o_v_fetch_req, o_cu_valid, o_wr_en, o_busy, o_done, o_err} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=0000000",
        {o_qk_fetch_req, o_v_fetch_req, o_cu_valid, o_wr_en, o_busy, o_done, o_err});
    end
    checks++;
    if (o_q_idx !== '0 || o_kv_idx !== '0 || o_wr_addr !== '0) begin
      errors++; $display("FAIL reset_idx got q=%0d kv=%0d addr=%0d want 0/0/0", o_q_idx, o_kv_idx, o_wr_addr);
    end
  endtask

  task automatic test_normal();
    int d0;
    int n;
    d0 = done_cnt;
    start_job(2, 3);
    checks++;
    if (o_busy !== 1'b1 || o_wr_addr !== '0) begin
      errors++; $display("FAIL normal_start got busy=%b addr=%0d want 1/0", o_busy, o_wr_addr);
    end
    for (int r = 0; r < 6; r++) begin
      checks++;
      if (o_qk_fetch_req !== 1'b1 || o_q_idx !== CW'(r / 3) || o_kv_idx !== CW'(r % 3)) begin
        errors++; $display("FAIL round%0d_fetch got req=%b q=%0d kv=%0d want 1 %0d %0d",
          r, o_qk_fetch_req, o_q_idx, o_kv_idx, r / 3, r % 3);
      end
      i_qk_fetch_ack = 1'b1; cyc(); i_qk_fetch_ack = 1'b0;
      checks++;
      if (o_cu_valid !== 1'b1 || o_qk_fetch_req !== 1'b0) begin
        errors++; $display("FAIL round%0d_qk got cu_valid=%b req=%b want 1/0", r, o_cu_valid, o_qk_fetch_req);
      end
      cyc();
      checks++;
      if (o_cu_valid !== 1'b1) begin
        errors++; $display("FAIL round%0d_qk_hold got cu_valid=%b want 1", r, o_cu_valid);
      end
      i_cu_qk_over = 1'b1; cyc(); i_cu_qk_over = 1'b0;
      checks++;
      if (o_cu_valid !== 1'b0 || o_v_fetch_req !== 1'b1) begin
        errors++; $display("FAIL round%0d_fetch_v got cu_valid=%b vreq=%b want 0/1", r, o_cu_valid, o_v_fetch_req);
      end
      i_v_fetch_ack = 1'b1; cyc(); i_v_fetch_ack = 1'b0;
      checks++;
      if (o_v_fetch_req !== 1'b0 || o_busy !== 1'b1) begin
        errors++; $display("FAIL round%0d_sv got vreq=%b busy=%b want 0/1", r, o_v_fetch_req, o_busy);
      end
      i_cu_over = 1'b1; i_cu_data_valid = 1'b1; cyc(); i_cu_over = 1'b0; i_cu_data_valid = 1'b0;
      checks++;
      if (o_wr_en !== 1'b1 || o_wr_addr !== AW'(r)) begin
        errors++; $display("FAIL round%0d_write got en=%b addr=%0d want 1 %0d", r, o_wr_en, o_wr_addr, r);
      end
    end
    n = 0;
    while (o_done !== 1'b1 && n < 40) begin cyc(); n++; end
    checks++;
    if (n != DQ) begin
      errors++; $display("FAIL drain_len got=%0d want=%0d", n, DQ);
    end
    cyc();
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || done_cnt != d0 + 1) begin
      errors++; $display("FAIL normal_done got done=%b busy=%b pulses=%0d want 0 0 1", o_done, o_busy, done_cnt - d0);
    end
    checks++;
    if (o_q_idx !== CW'(2) || o_kv_idx !== CW'(0)) begin
      errors++; $display("FAIL normal_final_idx got q=%0d kv=%0d want 2 0", o_q_idx, o_kv_idx);
    end
  endtask

  task automatic test_zero_count();
    start_job(5, 0);
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_qk_fetch_req !== 1'b0) begin
      errors++; $display("FAIL zero_done got done=%b busy=%b req=%b want 1 0 0", o_done, o_busy, o_qk_fetch_req);
    end
    cyc();
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_qk_fetch_req !== 1'b0) begin
      errors++; $display("FAIL zero_after got done=%b busy=%b req=%b want 0 0 0", o_done, o_busy, o_qk_fetch_req);
    end
  endtask

  task automatic test_writes();
    int n;
    start_job(1, 1);
    for (int i = 0; i < 5; i++) begin
      i_cu_data_valid = 1'b1; cyc(); i_cu_data_valid = 1'b0;
      checks++;
      if (o_wr_en !== 1'b1 || o_wr_addr !== AW'(i)) begin
        errors++; $display("FAIL write%0d got en=%b addr=%0d want 1 %0d", i, o_wr_en, o_wr_addr, i);
      end
      cyc();
      checks++;
      if (o_wr_en !== 1'b0) begin
        errors++; $display("FAIL write%0d_gap got en=%b want 0", i, o_wr_en);
      end
    end
    i_abort = 1'b1; cyc(); i_abort = 1'b0;
    start_job(1, 1);
    i_qk_fetch_ack = 1'b1; cyc(); i_qk_fetch_ack = 1'b0;
    i_cu_qk_over = 1'b1; cyc(); i_cu_qk_over = 1'b0;
    i_v_fetch_ack = 1'b1; cyc(); i_v_fetch_ack = 1'b0;
    i_cu_over = 1'b1; cyc(); i_cu_over = 1'b0;
    i_cu_data_valid = 1'b1;
    for (int i = 0; i <= 1024; i++) begin
      cyc();
      if (i == 1023) begin
        checks++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== AW'(1023)) begin
          errors++; $display("FAIL wrap_top got en=%b addr=%0d want 1 1023", o_wr_en, o_wr_addr);
        end
      end
      if (i == 1024) begin
        checks++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== AW'(0) || o_busy !== 1'b1) begin
          errors++; $display("FAIL wrap_zero got en=%b addr=%0d busy=%b want 1 0 1", o_wr_en, o_wr_addr, o_busy);
        end
      end
    end
    i_cu_data_valid = 1'b0;
    n = 0;
    while (o_done !== 1'b1 && n < 40) begin cyc(); n++; end
    checks++;
    if (n != DQ) begin
      errors++; $display("FAIL wrap_drain_len got=%0d want=%0d", n, DQ);
    end
  endtask

  task automatic test_abort();
    int d0;
    start_job(2, 3);
    i_qk_fetch_ack = 1'b1; cyc(); i_qk_fetch_ack = 1'b0;
    i_cu_qk_over = 1'b1; cyc(); i_cu_qk_over = 1'b0;
    i_v_fetch_ack = 1'b1; cyc(); i_v_fetch_ack = 1'b0;
    i_cu_over = 1'b1; cyc(); i_cu_over = 1'b0;
    start_job(0, 0);
    checks++;
    if (o_qk_fetch_req !== 1'b1 || o_done !== 1'b0 || o_kv_idx !== CW'(1)) begin
      errors++; $display("FAIL start_ignored got req=%b done=%b kv=%0d want 1 0 1", o_qk_fetch_req, o_done, o_kv_idx);
    end
    i_qk_fetch_ack = 1'b1; cyc(); i_qk_fetch_ack = 1'b0;
    i_cu_qk_over = 1'b1; cyc(); i_cu_qk_over = 1'b0;
    i_v_fetch_ack = 1'b1; cyc(); i_v_fetch_ack = 1'b0;
    d0 = done_cnt;
    i_cu_over = 1'b1; i_abort = 1'b1; cyc(); i_cu_over = 1'b0; i_abort = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_q_idx !== CW'(0) || o_kv_idx !== CW'(1) || o_done !== 1'b0) begin
      errors++; $display("FAIL abort_sv got busy=%b q=%0d kv=%0d done=%b want 0 0 1 0", o_busy, o_q_idx, o_kv_idx, o_done);
    end
    checks++;
    if (o_qk_fetch_req !== 1'b0 || o_v_fetch_req !== 1'b0 || o_cu_valid !== 1'b0) begin
      errors++; $display("FAIL abort_req got qk=%b v=%b cu=%b want 0 0 0", o_qk_fetch_req, o_v_fetch_req, o_cu_valid);
    end
    repeat (20) cyc();
    checks++;
    if (done_cnt != d0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL abort_quiet got pulses=%0d busy=%b want 0 0", done_cnt - d0, o_busy);
    end
  endtask

  task automatic test_reset_mid();
    start_job(1, 1);
    i_qk_fetch_ack = 1'b1; cyc(); i_qk_fetch_ack = 1'b0;
    checks++;
    if (o_cu_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got cu_valid=%b want 1", o_cu_valid);
    end
    rst = 1'b1; cyc(); rst = 1'b0;
    checks++;
    if (o_cu_valid !== 1'b0 || o_busy !== 1'b0 || o_qk_fetch_req !== 1'b0) begin
      errors++; $display("FAIL rstmid got cu_valid=%b busy=%b req=%b want 0 0 0", o_cu_valid, o_busy, o_qk_fetch_req);
    end
    start_job(1, 1);
    checks++;
    if (o_qk_fetch_req !== 1'b1) begin
      errors++; $display("FAIL rstmid_idle got req=%b want 1", o_qk_fetch_req);
    end
    i_abort = 1'b1; cyc(); i_abort = 1'b0;
  endtask

  task automatic test_timeout();
    start_job(1, 1);
    i_qk_fetch_ack = 1'b1; cyc(); i_qk_fetch_ack = 1'b0;
    i_cu_qk_over = 1'b1; cyc(); i_cu_qk_over = 1'b0;
    repeat (TO - 1) cyc();
    checks++;
    if (o_err !== 1'b0 || o_v_fetch_req !== 1'b1) begin
      errors++; $display("FAIL timeout_early got err=%b vreq=%b want 0 1", o_err, o_v_fetch_req);
    end
    cyc();
    checks++;
    if (o_err !== 1'b1 || o_v_fetch_req !== 1'b0 || o_busy !== 1'b0 || o_cu_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_err got err=%b vreq=%b busy=%b cu=%b want 1 0 0 0",
        o_err, o_v_fetch_req, o_busy, o_cu_valid);
    end
    i_start = 1'b1; i_abort = 1'b1; i_v_fetch_ack = 1'b1;
    repeat (5) cyc();
    i_start = 1'b0; i_abort = 1'b0; i_v_fetch_ack = 1'b0;
    checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL err_sticky got err=%b busy=%b want 1 0", o_err, o_busy);
    end
    rst = 1'b1; cyc(); rst = 1'b0;
    checks++;
    if (o_err !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL err_reset got err=%b busy=%b want 0 0", o_err, o_busy);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_normal();
    test_zero_count();
    test_writes();
    test_abort();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
